// File: rtl/sound_arbiter_pkg.sv
// Shared constants for the sound arbiter: sound codes, requester indices and
// the FSM state encoding.
package sound_arbiter_pkg;

  typedef logic [2:0] sound_code_t;

  localparam sound_code_t SND_MOVE      = 3'd0;
  localparam sound_code_t SND_CAPTURE   = 3'd1;
  localparam sound_code_t SND_CHECK     = 3'd2;
  localparam sound_code_t SND_PROMOTION = 3'd3;
  localparam sound_code_t SND_WIN       = 3'd4;
  localparam sound_code_t SND_DRAW      = 3'd5;

  localparam int NUM_REQ      = 4;
  localparam int REQ_GAMEOVER = 0;
  localparam int REQ_CHECK    = 1;
  localparam int REQ_CAPTURE  = 2;
  localparam int REQ_MOVE     = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/sound_prio_pick.sv
// Fixed-priority pick: lowest-index valid slot wins, and its code is muxed out.
module sound_prio_pick
  import sound_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   i_pend_v,
  input  logic [3*NUM_REQ-1:0] i_codes,
  output logic [NUM_REQ-1:0]   o_onehot,
  output sound_code_t          o_code
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    o_onehot = '0;
    o_code   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_pend_v[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_code      = i_codes[3*i +: 3];
      end
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Arbitrates four sound requesters onto a single Sound player, enforcing a
// minimum spacing of HOLD_CYCLES between play_sound strobes.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 20000000,
  parameter int CNT_W       = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [11:0] req_code,
  input  logic        mute,
  output logic [2:0]  sound_code,
  output logic        play_sound,
  output logic [3:0]  grant,
  output logic [3:0]  drop,
  output logic        busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pend_v;
  logic [11:0]      r_pend_code;
  sound_code_t      r_sound_code;
  logic             r_play;
  logic [3:0]       r_grant;
  logic [3:0]       r_drop;

  logic [3:0]       w_win;
  sound_code_t      w_code;
  logic             w_issue;

  sound_prio_pick u_pick (
    .i_pend_v (r_pend_v),
    .i_codes  (r_pend_code),
    .o_onehot (w_win),
    .o_code   (w_code)
  );

  // While muted the slots are being flushed, so nothing may be issued from them.
  assign w_issue = (|r_pend_v) && !mute &&
                   ((r_state == ST_IDLE) || (r_cnt == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_play       <= 1'b0;
      r_grant      <= '0;
      r_sound_code <= '0;
    end else begin
      r_play  <= w_issue;
      r_grant <= w_issue ? w_win : 4'b0000;
      if (w_issue) begin
        r_sound_code <= w_code;
        r_cnt        <= HOLD_LOAD;
        r_state      <= ST_HOLD;
      end else if (r_state == ST_HOLD) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  // A new request on a slot being granted this edge refills it without a drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_v    <= '0;
      r_pend_code <= '0;
      r_drop      <= '0;
    end else begin
      r_drop <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (mute) begin
          r_pend_v[i] <= 1'b0;
        end else if (req[i]) begin
          r_pend_v[i]           <= 1'b1;
          r_pend_code[3*i +: 3] <= req_code[3*i +: 3];
          r_drop[i]             <= r_pend_v[i] & ~(w_issue & w_win[i]);
        end else if (w_issue && w_win[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
    end
  end

  assign sound_code = r_sound_code;
  assign play_sound = r_play;
  assign grant      = r_grant;
  assign drop       = r_drop;
  assign busy       = (r_state == ST_HOLD);

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 20000000, minimum cycles between successive play_sound pulses; legal range 2 to 2^25-1.
REQ-002 Parameter CNT_W, default 25, width of the hold counter; it SHALL hold HOLD_CYCLES-1.
REQ-003 clk  input  1  system clock, the same clk that drives Play and Sound.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 req  input  4  per-requester one-cycle request strobe; bit 0 is highest priority, for example game over.
REQ-006 req_code  input  12  packed 3-bit sound codes; bits [3i+2:3i] belong to requester i and are sampled only when req[i]=1.
REQ-007 mute  input  1  level; while high, all requests are discarded.
REQ-008 sound_code  output  3  code presented to Sound.
REQ-009 play_sound  output  1  one-cycle start strobe to Sound.
REQ-010 grant  output  4  one-hot strobe marking the requester served, coincident with play_sound.
REQ-011 drop  output  4  one-cycle strobe marking a requester whose pending entry was overwritten.
REQ-012 busy  output  1  high while in the HOLD state.

Function
REQ-013 Each requester SHALL own a one-entry pending slot consisting of a valid bit and a 3-bit code.
REQ-014 If req[i]=1 and mute=0, the next edge SHALL set pend_v[i] and store req_code[3i+2:3i].
REQ-015 If req[i]=1 arrives while pend_v[i]=1 and the slot is not granted at that edge, the new code SHALL overwrite the slot and drop[i] SHALL pulse for one cycle.
REQ-016 The FSM SHALL have two states: IDLE and HOLD.
REQ-017 A cycle is an issue edge when pending is non-zero and either state=IDLE, or state=HOLD with cnt=0.
REQ-018 Arbitration is fixed priority: the winner is the lowest-index set pend_v bit.
REQ-019 At an issue edge the block SHALL, registered:
- assert play_sound=1;
- drive sound_code with the winner's code;
- assert grant with the winner's bit only;
- clear the winner's pend_v;
- load cnt with HOLD_CYCLES-1;
- enter HOLD.
REQ-020 At every other edge, play_sound, grant and drop SHALL return to 0.
REQ-021 sound_code SHALL hold its last issued value outside play_sound cycles.
REQ-022 In HOLD with cnt>0, cnt SHALL decrement by 1 each edge.
REQ-023 In HOLD with cnt=0 and no pending entry, the FSM SHALL return to IDLE.
REQ-024 Latency: a req in cycle t with the FSM in IDLE SHALL give play_sound in cycle t+2.
REQ-025 Spacing: consecutive play_sound pulses SHALL be exactly HOLD_CYCLES cycles apart when work is pending.
REQ-026 If req[i] coincides with the grant of slot i, the slot SHALL stay valid with the new code, and drop[i] SHALL remain 0.
REQ-027 Simultaneous requests on several bits SHALL all be captured and then served in index order.
REQ-028 mute=1 SHALL clear all pend_v at the next edge and block capture.
REQ-029 mute SHALL NOT cut a HOLD already in progress, and SHALL NOT suppress a play_sound already registered.
REQ-030 Lower-index requests arriving during HOLD SHALL pre-empt older higher-index pending entries at the next issue edge.
REQ-031 busy SHALL be 1 exactly when state=HOLD.

Reset
REQ-032 While rstn=0, the block SHALL hold: state=IDLE, cnt=0, pend_v=0, all pending codes=0, sound_code=0, play_sound=0, grant=0, drop=0, busy=0.
REQ-033 Reset asserted mid-HOLD or with entries pending SHALL discard all pending entries, and no play_sound SHALL follow reset release without a new req.

Structure
REQ-034 The shared chess package SHALL hold:
- the 3-bit sound code constants (move, capture, check, promotion, win, draw);
- the requester index constants;
- the FSM state encoding.
REQ-035 The priority pick (pend_v to one-hot winner plus mux of the winner's code) is the single sub-module, named sound_prio_pick; everything else stays in sound_arbiter.

Verification (HOLD_CYCLES=8)
REQ-036 Single request:
- stimulus: req=0001, code 3'd5 at cycle 10;
- response: play_sound, grant=0001 and sound_code=5 in cycle 12; busy high in cycles 12-19; busy low from cycle 20.
REQ-037 Simultaneous requests:
- stimulus: req=1010 with codes 2 (bit 1) and 6 (bit 3) at cycle 10;
- response: grant=0010 with code 2 at cycle 12; grant=1000 with code 6 at cycle 20; no drop.
REQ-038 Overwrite:
- stimulus: req[2] with code 1 at cycle 10, then req[2] with code 4 at cycle 13, during HOLD from req[0] granted at cycle 10;
- response: drop=0100 at cycle 14; req[2] later granted once, with code 4.
REQ-039 Pre-emption:
- stimulus: req[3] pending, then req[0] arriving during HOLD;
- response: the next issue edge grants bit 0 first, and bit 3 follows HOLD_CYCLES later.
REQ-040 Mute:
- stimulus: mute=1 with 3 entries pending, held for 1 cycle;
- response: the current HOLD runs to completion, the FSM returns to IDLE, and no further play_sound occurs.
REQ-041 Reset mid-operation:
- stimulus: rstn low for 3 cycles at cnt=4 with 2 entries pending;
- response: all outputs read 0 during reset, and no play_sound occurs after release for 20 idle cycles.
